// File: rtl/sort_step_ctrl_if.sv
// Handshake bundle between the switch/button front end (master) and the step-wise sorter (slave).
// Element k of din/nums is packed at [k*WIDTH +: WIDTH].
interface sort_step_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 load;
  logic [4*WIDTH-1:0]   din;
  logic                 step;
  logic [4*WIDTH-1:0]   nums;
  logic                 sorting_done;
  logic                 busy;
  logic [1:0]           cmp_idx;
  logic [3:0]           swap_count;

  modport master (
    output load, din, step,
    input  nums, sorting_done, busy, cmp_idx, swap_count
  );

  modport slave (
    input  load, din, step,
    output nums, sorting_done, busy, cmp_idx, swap_count
  );
endinterface

// File: rtl/sort_step_ctrl.sv
// Four-element bubble sort, one registered compare-and-swap per step; load restarts at once, no stall.
// SORT_AUTO_STEP_EN: steps come from an internal STEP_DIV-cycle divider instead of the step port.
module sort_step_ctrl #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 100_000_000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sort_step_ctrl_if.slave io_sort
);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t             r_state;
  logic [4*WIDTH-1:0] r_nums;
  logic [1:0]         r_pass;
  logic [1:0]         r_cmp_idx;
  logic               r_pass_swapped;
  logic [3:0]         r_swap_count;
  logic               r_busy;
  logic               r_done;

  logic               w_step;
  logic [1:0]         w_idx_hi;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_swap;
  logic               w_last;
  logic [4*WIDTH-1:0] w_nums_sw;

`ifdef SORT_AUTO_STEP_EN
  localparam int               CNT_W   = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
  logic [CNT_W-1:0] r_div_cnt;

  assign w_step = (r_div_cnt == CNT_MAX);
`else
  assign w_step = io_sort.step;
`endif

  assign w_idx_hi = r_cmp_idx + 2'd1;
  assign w_a      = r_nums[r_cmp_idx*WIDTH +: WIDTH];
  assign w_b      = r_nums[w_idx_hi*WIDTH +: WIDTH];
  assign w_swap   = (w_a > w_b);
  assign w_last   = (r_cmp_idx == (2'd2 - r_pass));

  always_comb begin
    w_nums_sw = r_nums;
    w_nums_sw[r_cmp_idx*WIDTH +: WIDTH] = w_b;
    w_nums_sw[w_idx_hi*WIDTH +: WIDTH]  = w_a;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_nums         <= '0;
      r_pass         <= 2'd0;
      r_cmp_idx      <= 2'd0;
      r_pass_swapped <= 1'b0;
      r_swap_count   <= 4'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
`ifdef SORT_AUTO_STEP_EN
      r_div_cnt      <= '0;
`endif
    end else begin
`ifdef SORT_AUTO_STEP_EN
      // Divider only runs in SORT so the first auto step lands STEP_DIV cycles after load.
      if (io_sort.load || r_state != SORT || r_div_cnt == CNT_MAX) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
`endif
      if (io_sort.load) begin
        r_state        <= SORT;
        r_nums         <= io_sort.din;
        r_pass         <= 2'd0;
        r_cmp_idx      <= 2'd0;
        r_pass_swapped <= 1'b0;
        r_swap_count   <= 4'd0;
        r_busy         <= 1'b1;
        r_done         <= 1'b0;
      end else if (w_step && r_state == SORT) begin
        if (w_swap) begin
          r_nums       <= w_nums_sw;
          r_swap_count <= r_swap_count + 4'd1;
        end
        if (w_last) begin
          // A clean pass means the array is ordered; pass 2 is the last one regardless.
          if (!(r_pass_swapped || w_swap) || r_pass == 2'd2) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_pass         <= r_pass + 2'd1;
            r_cmp_idx      <= 2'd0;
            r_pass_swapped <= 1'b0;
          end
        end else begin
          r_cmp_idx <= r_cmp_idx + 2'd1;
          if (w_swap) begin
            r_pass_swapped <= 1'b1;
          end
        end
      end
    end
  end

  assign io_sort.nums         = r_nums;
  assign io_sort.sorting_done = r_done;
  assign io_sort.busy         = r_busy;
  assign io_sort.cmp_idx      = r_cmp_idx;
  assign io_sort.swap_count   = r_swap_count;
endmodule
